adder_unit: RTL and testbench

32-bit registered two's-complement adder/subtractor used as a general datapath arithmetic block, e.g. PC+4 and branch-target computation in the MIPS core. The carry chain is a carry-lookahead structure. The sum is captured in an output register, so the result is valid one clock after the operands. Status flags are an optional compile-time feature.

---
 rtl/adder_unit.sv | 139 +++++++++++++
 tb/tb_adder_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/adder_unit.sv
// rtl/adder_unit.sv - 32-bit registered two-level carry-lookahead adder/subtractor; flags under ADDER_FLAGS_EN
module adder_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        in_valid,
    output logic [31:0] y,
    output logic        out_valid
`ifdef ADDER_FLAGS_EN
    ,
    output logic        cout,
    output logic        ovf,
    output logic        zero
`endif
);

    // Group generate/propagate for one 4-bit slice, independent of its carry-in.
    function automatic logic [1:0] group_gp(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        logic gp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gg, gp};
    endfunction

    // Carries into bits 0..3 of a slice, each a flat sum-of-products of the slice carry-in.
    function automatic logic [3:0] group_carry(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Second-level unit: carry into group k expanded as OR of G[j]&P[j+1..k-1] terms.
    function automatic logic lookahead(input logic [7:0] gg, input logic [7:0] gp,
                                       input logic ci, input int k);
        logic c;
        logic t;
        c = ci;
        for (int m = 0; m < k; m++) c = c & gp[m];
        for (int j = 0; j < k; j++) begin
            t = gg[j];
            for (int m = j + 1; m < k; m++) t = t & gp[m];
            c = c | t;
        end
        return c;
    endfunction

    logic [31:0] bb;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [31:0] sum;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_c;
    logic        cin;

    assign cin = sub;
    assign bb  = sub ? ~b : b;
    assign g   = a & bb;
    assign p   = a ^ bb;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        assign {grp_g[k], grp_p[k]} = group_gp(g[4*k +: 4], p[4*k +: 4]);
        assign grp_c[k]             = lookahead(grp_g, grp_p, cin, k);
        assign c[4*k +: 4]          = group_carry(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
    end

    assign sum = p ^ c;

    logic [31:0] y_q;
    logic [31:0] y_d;
    logic        valid_q;
    logic        valid_d;

    always_comb begin
        y_d     = y_q;
        valid_d = in_valid;
        if (in_valid) begin
            y_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = valid_q;

`ifdef ADDER_FLAGS_EN
    logic carry_out;
    logic cout_q, cout_d;
    logic ovf_q, ovf_d;
    logic zero_q, zero_d;

    assign carry_out = lookahead(grp_g, grp_p, cin, 8);

    always_comb begin
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (in_valid) begin
            cout_d = carry_out;
            ovf_d  = (a[31] == bb[31]) && (sum[31] != a[31]);
            zero_d = (sum == 32'd0);
        end
    end

    // zero is a registered flag, so it reads 0 in reset even though y is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_adder_unit.sv
// tb/tb_adder_unit.sv - directed self-checking bench for adder_unit; flag checks under ADDER_FLAGS_EN
module tb_adder_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        in_valid;
    logic [31:0] y;
    logic        out_valid;
`ifdef ADDER_FLAGS_EN
    logic        cout;
    logic        ovf;
    logic        zero;
`endif

    int checks;
    int failures;

    adder_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid)
`ifdef ADDER_FLAGS_EN
        ,
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic c_e, input logic o_e, input logic z_e);
`ifdef ADDER_FLAGS_EN
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, c_e});
        chk({tag, ".ovf"},  {31'd0, ovf},  {31'd0, o_e});
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, z_e});
`else
        if (tag.len() == 0) $display("%b%b%b", c_e, o_e, z_e);
`endif
    endtask

    // Apply operands, let one rising edge capture them, then sample 1 time unit later.
    task automatic step(input logic [31:0] av, input logic [31:0] bv, input logic s, input logic v);
        a        = av;
        b        = bv;
        sub      = s;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        a        = $urandom;
        b        = $urandom;
        sub      = 1'b0;
        in_valid = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        chk("reset.y", y, 32'd0);
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk_flags("reset", 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        chk("reset_hold.y", y, 32'd0);

        step(32'd5, 32'd6, 1'b0, 1'b1);
        chk("add5_6.y", y, 32'd11);
        chk("add5_6.valid", {31'd0, out_valid}, 32'd1);
        chk_flags("add5_6", 1'b0, 1'b0, 1'b0);

        step(32'd6, 32'd9, 1'b0, 1'b1);
        chk("add6_9.y", y, 32'd15);
        chk("add6_9.valid", {31'd0, out_valid}, 32'd1);
        chk_flags("add6_9", 1'b0, 1'b0, 1'b0);

        step(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        chk("wrap.y", y, 32'd0);
        chk_flags("wrap", 1'b1, 1'b0, 1'b1);

        step(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
        chk("ovf_add.y", y, 32'h8000_0000);
        chk_flags("ovf_add", 1'b0, 1'b1, 1'b0);

        step(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        chk("ovf_sub.y", y, 32'h7FFF_FFFF);
        chk_flags("ovf_sub", 1'b1, 1'b1, 1'b0);

        step(32'd9, 32'd6, 1'b1, 1'b1);
        chk("sub9_6.y", y, 32'd3);
        chk_flags("sub9_6", 1'b1, 1'b0, 1'b0);

        step(32'd6, 32'd9, 1'b1, 1'b1);
        chk("sub6_9.y", y, 32'hFFFF_FFFD);
        chk_flags("sub6_9", 1'b0, 1'b0, 1'b0);

        step(32'h1234_0000, 32'h0000_0777, 1'b0, 1'b0);
        chk("hold1.y", y, 32'hFFFF_FFFD);
        chk("hold1.valid", {31'd0, out_valid}, 32'd0);
        chk_flags("hold1", 1'b0, 1'b0, 1'b0);

        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("hold2.y", y, 32'hFFFF_FFFD);
        chk("hold2.valid", {31'd0, out_valid}, 32'd0);

        step(32'h0000_FFFF, 32'd1, 1'b0, 1'b1);
        chk("grpcarry.y", y, 32'h0001_0000);
        chk("grpcarry.valid", {31'd0, out_valid}, 32'd1);
        chk_flags("grpcarry", 1'b0, 1'b0, 1'b0);

        step(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
        chk("mixed.y", y, 32'h9999_9999);
        chk_flags("mixed", 1'b0, 1'b0, 1'b0);

        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("subeq.y", y, 32'd0);
        chk_flags("subeq", 1'b1, 1'b0, 1'b1);

        step(32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 1'b1);
        chk("subpat.y", y, 32'h0E10_0E10);
        chk_flags("subpat", 1'b1, 1'b0, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        chk("midrst.y", y, 32'd0);
        chk("midrst.valid", {31'd0, out_valid}, 32'd0);
        chk_flags("midrst", 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;

        step(32'd1, 32'd2, 1'b0, 1'b1);
        chk("postrst.y", y, 32'd3);
        chk("postrst.valid", {31'd0, out_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
